// File: rtl/param_datapath_if.sv
`default_nettype none
// =============================================================================
// param_datapath_if : control and status bundle for param_datapath
// Revision: 1.0
// =============================================================================
interface param_datapath_if #(
    parameter int NREGS  = 4,
    parameter int DIGITS = 5
);
    localparam int c_sel_w = $clog2(NREGS);

    logic [c_sel_w-1:0]  reg_sel;
    logic                gp_reg_write;
    logic                gp_reg_read;
    logic [3:0]          ula_operation;
    logic                grab_ula;
    logic                store_data_bus;
    logic                store_hi;
    logic                flag_zero;
    logic                flag_carry;
    logic [4*DIGITS-1:0] bcd_out;
    logic                bcd_busy;
    logic                bcd_valid;

    modport master (
        output reg_sel, gp_reg_write, gp_reg_read, ula_operation,
               grab_ula, store_data_bus, store_hi,
        input  flag_zero, flag_carry, bcd_out, bcd_busy, bcd_valid
    );

    modport slave (
        input  reg_sel, gp_reg_write, gp_reg_read, ula_operation,
               grab_ula, store_data_bus, store_hi,
        output flag_zero, flag_carry, bcd_out, bcd_busy, bcd_valid
    );
endinterface
`default_nettype wire

// File: rtl/param_datapath.sv
`default_nettype none
// =============================================================================
// param_datapath : register file, ALU, result latch on a tristate bus and a
//                  double-dabble BCD converter fed from the ALU result.
// Revision: 1.0
// =============================================================================
module param_datapath #(
    parameter int WIDTH  = 8,
    parameter int NREGS  = 4,
    parameter int DIGITS = 5
) (
    input  logic             clock,
    input  logic             reset,
    param_datapath_if.slave  dp,
    inout  wire [WIDTH-1:0]  data_bus
);
    localparam int c_res_w      = 2 * WIDTH;
    localparam int c_bcd_w      = 4 * DIGITS;
    localparam int c_cnt_w      = $clog2(c_res_w);
    localparam int c_min_digits = (c_res_w * 30103) / 100000 + 1;
    localparam logic [c_cnt_w-1:0] c_last_shift = c_cnt_w'(c_res_w - 1);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOT  = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_SHR  = 4'd7;
    localparam logic [3:0] OP_MUL  = 4'd8;
    localparam logic [3:0] OP_PASS = 4'd9;

    if (WIDTH < 4) begin : g_chk_width
        $error("WIDTH must be at least 4");
    end
    if (NREGS < 2 || (NREGS & (NREGS - 1)) != 0) begin : g_chk_nregs
        $error("NREGS must be a power of two and at least 2");
    end
    if (DIGITS < c_min_digits) begin : g_chk_digits
        $error("DIGITS too small for a 2*WIDTH-bit result");
    end

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t               r_state, w_state_next;
    logic [WIDTH-1:0]     r_regs [NREGS];
    logic [WIDTH-1:0]     r_opnd;
    logic [c_res_w-1:0]   r_latch;
    logic                 r_flag_zero, r_flag_carry;
    logic [c_res_w-1:0]   r_bin;
    logic [c_bcd_w-1:0]   r_scratch, r_bcd;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_busy, r_valid;

    logic                 w_drive_en;
    logic [WIDTH-1:0]     w_drive_half, w_bus_in;
    logic [WIDTH:0]       w_sum, w_diff;
    logic [c_res_w-1:0]   w_prod, w_alu_r;
    logic                 w_alu_c;
    logic [c_bcd_w-1:0]   w_adj, w_scr_shift;
    logic [c_res_w-1:0]   w_bin_shift;
    logic                 w_load, w_shift, w_done;

    // The bus is released during reset; our own drive is looped back
    // internally so the register-move path does not depend on net resolution.
    assign w_drive_en   = dp.store_data_bus & ~reset;
    assign w_drive_half = dp.store_hi ? r_latch[c_res_w-1:WIDTH] : r_latch[WIDTH-1:0];
    assign data_bus     = w_drive_en ? w_drive_half : {WIDTH{1'bz}};
    assign w_bus_in     = w_drive_en ? w_drive_half : data_bus;

    assign w_sum  = {1'b0, r_opnd} + {1'b0, w_bus_in};
    assign w_diff = {1'b0, r_opnd} - {1'b0, w_bus_in};
    assign w_prod = {{WIDTH{1'b0}}, r_opnd} * {{WIDTH{1'b0}}, w_bus_in};

    always_comb begin
        w_alu_r = '0;
        w_alu_c = 1'b0;
        case (dp.ula_operation)
            OP_ADD:  begin
                w_alu_r = {{(WIDTH-1){1'b0}}, w_sum};
                w_alu_c = w_sum[WIDTH];
            end
            OP_SUB:  begin
                w_alu_r = {{WIDTH{1'b0}}, w_diff[WIDTH-1:0]};
                w_alu_c = w_diff[WIDTH];
            end
            OP_AND:  w_alu_r = {{WIDTH{1'b0}}, r_opnd & w_bus_in};
            OP_OR:   w_alu_r = {{WIDTH{1'b0}}, r_opnd | w_bus_in};
            OP_XOR:  w_alu_r = {{WIDTH{1'b0}}, r_opnd ^ w_bus_in};
            OP_NOT:  w_alu_r = {{WIDTH{1'b0}}, ~r_opnd};
            OP_SHL:  begin
                w_alu_r = {{WIDTH{1'b0}}, r_opnd[WIDTH-2:0], 1'b0};
                w_alu_c = r_opnd[WIDTH-1];
            end
            OP_SHR:  begin
                w_alu_r = {{WIDTH{1'b0}}, 1'b0, r_opnd[WIDTH-1:1]};
                w_alu_c = r_opnd[0];
            end
            OP_MUL:  begin
                w_alu_r = w_prod;
                w_alu_c = |w_prod[c_res_w-1:WIDTH];
            end
            OP_PASS: w_alu_r = {{WIDTH{1'b0}}, w_bus_in};
            default: ;
        endcase
    end

    // Double-dabble step: correct digits >= 5, then shift binary MSB in.
    always_comb begin
        w_adj = r_scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_scratch[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
            end
        end
        w_scr_shift = {w_adj[c_bcd_w-2:0], r_bin[c_res_w-1]};
        w_bin_shift = {r_bin[c_res_w-2:0], 1'b0};
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        w_done       = 1'b0;
        if (dp.grab_ula) begin
            w_load       = 1'b1;
            w_state_next = S_SHIFT;
        end else if (r_state == S_SHIFT) begin
            w_shift = 1'b1;
            if (r_cnt == c_last_shift) begin
                w_done       = 1'b1;
                w_state_next = S_IDLE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_opnd       <= '0;
            r_latch      <= '0;
            r_flag_zero  <= 1'b0;
            r_flag_carry <= 1'b0;
            r_bin        <= '0;
            r_scratch    <= '0;
            r_cnt        <= '0;
            r_bcd        <= '0;
            r_busy       <= 1'b0;
            r_valid      <= 1'b0;
        end else begin
            if (dp.gp_reg_write) begin
                r_regs[dp.reg_sel] <= w_bus_in;
            end
            if (dp.gp_reg_read) begin
                r_opnd <= r_regs[dp.reg_sel];
            end
            if (dp.grab_ula) begin
                r_latch      <= w_alu_r;
                r_flag_carry <= w_alu_c;
                r_flag_zero  <= (w_alu_r == '0);
            end
            if (w_load) begin
                r_bin     <= w_alu_r;
                r_scratch <= '0;
                r_cnt     <= '0;
                r_busy    <= 1'b1;
                r_valid   <= 1'b0;
            end else if (w_shift) begin
                r_bin     <= w_bin_shift;
                r_scratch <= w_scr_shift;
                r_cnt     <= r_cnt + 1'b1;
                if (w_done) begin
                    r_bcd   <= w_scr_shift;
                    r_valid <= 1'b1;
                    r_busy  <= 1'b0;
                end
            end
        end
    end

    assign dp.flag_zero  = r_flag_zero;
    assign dp.flag_carry = r_flag_carry;
    assign dp.bcd_out    = r_bcd;
    assign dp.bcd_busy   = r_busy;
    assign dp.bcd_valid  = r_valid;
endmodule
`default_nettype wire

// File: tb/tb_param_datapath.sv
`default_nettype none
// =============================================================================
// tb_param_datapath : directed scenarios plus randomized traffic compared
//                     against an arithmetic reference model.
// Revision: 1.0
// =============================================================================
module tb_param_datapath;
    localparam int W = 8;
    localparam int N = 4;
    localparam int D = 5;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       tb_en = 1'b0;
    logic [7:0] tb_val = 8'h00;
    wire  [7:0] data_bus;
    int         total = 0;
    int         bad = 0;

    param_datapath_if #(.NREGS(N), .DIGITS(D)) bus_if ();

    param_datapath #(.WIDTH(W), .NREGS(N), .DIGITS(D)) dut (
        .clock    (clock),
        .reset    (reset),
        .dp       (bus_if),
        .data_bus (data_bus)
    );

    // A released bus reads back as all ones through the pull-ups.
    assign data_bus = tb_en ? tb_val : 8'bz;
    for (genvar gi = 0; gi < W; gi++) begin : g_pull
        pullup (data_bus[gi]);
    end

    always #5 clock = ~clock;

    // Reference model state
    logic [7:0]  m_regs [N];
    logic [7:0]  m_opnd = '0;
    logic [15:0] m_latch = '0;
    logic        m_zero = 1'b0, m_carry = 1'b0, m_valid = 1'b0, m_busy = 1'b0;
    logic [19:0] m_bcd = '0;
    int          m_left = 0;
    int          m_pend = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void ref_alu(input int op, input int a, input int b, output int r, output int c);
        r = 0;
        c = 0;
        case (op)
            0: begin r = a + b;         c = int'(r > 255); end
            1: begin r = (a - b) & 255; c = int'(a < b);   end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = 255 - a;
            6: begin r = (a * 2) % 256; c = a / 128; end
            7: begin r = a / 2;         c = a % 2;   end
            8: begin r = a * b;         c = int'(r > 255); end
            9: r = b;
            default: ;
        endcase
    endfunction

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] res;
        int          x;
        res = '0;
        x   = v;
        for (int d = 0; d < D; d++) begin
            res[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return res;
    endfunction

    function automatic logic [7:0] exp_bus();
        if (bus_if.store_data_bus && !reset) begin
            return bus_if.store_hi ? m_latch[15:8] : m_latch[7:0];
        end else if (tb_en) begin
            return tb_val;
        end
        return 8'hFF;
    endfunction

    task automatic model_step(input logic [7:0] b);
        int r, c;
        if (reset) begin
            for (int i = 0; i < N; i++) m_regs[i] = '0;
            m_opnd = '0; m_latch = '0; m_zero = 1'b0; m_carry = 1'b0;
            m_bcd = '0; m_valid = 1'b0; m_busy = 1'b0; m_left = 0;
        end else begin
            ref_alu(int'(bus_if.ula_operation), int'(m_opnd), int'(b), r, c);
            if (bus_if.gp_reg_read)  m_opnd = m_regs[bus_if.reg_sel];
            if (bus_if.gp_reg_write) m_regs[bus_if.reg_sel] = b;
            if (bus_if.grab_ula) begin
                m_latch = 16'(r);
                m_carry = c[0];
                m_zero  = (r == 0);
                m_pend  = r;
                m_left  = 2 * W;
                m_busy  = 1'b1;
                m_valid = 1'b0;
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_bcd   = to_bcd(m_pend);
                    m_valid = 1'b1;
                    m_busy  = 1'b0;
                end
            end
        end
    endtask

    task automatic do_cycle();
        logic [7:0] eb;
        #1;
        eb = exp_bus();
        check_val("data_bus", data_bus, eb);
        @(posedge clock);
        model_step(eb);
        #1;
        check_val("flag_zero", bus_if.flag_zero, m_zero);
        check_val("flag_carry", bus_if.flag_carry, m_carry);
        check_val("bcd_out", bus_if.bcd_out, m_bcd);
        check_val("bcd_valid", bus_if.bcd_valid, m_valid);
        check_val("bcd_busy", bus_if.bcd_busy, m_busy);
        @(negedge clock);
    endtask

    task automatic idle();
        bus_if.reg_sel        = '0;
        bus_if.gp_reg_write   = 1'b0;
        bus_if.gp_reg_read    = 1'b0;
        bus_if.ula_operation  = 4'd0;
        bus_if.grab_ula       = 1'b0;
        bus_if.store_data_bus = 1'b0;
        bus_if.store_hi       = 1'b0;
        tb_en  = 1'b0;
        tb_val = 8'h00;
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) begin
            idle();
            do_cycle();
        end
    endtask

    task automatic write_reg(input int sel, input logic [7:0] v);
        idle();
        bus_if.reg_sel      = 2'(sel);
        bus_if.gp_reg_write = 1'b1;
        tb_en  = 1'b1;
        tb_val = v;
        do_cycle();
    endtask

    task automatic read_reg(input int sel);
        idle();
        bus_if.reg_sel     = 2'(sel);
        bus_if.gp_reg_read = 1'b1;
        do_cycle();
    endtask

    task automatic grab_op(input logic [3:0] op, input logic [7:0] b);
        idle();
        bus_if.ula_operation = op;
        bus_if.grab_ula      = 1'b1;
        tb_en  = 1'b1;
        tb_val = b;
        do_cycle();
    endtask

    task automatic check_latch(input string tag, input logic [15:0] v);
        idle();
        bus_if.store_data_bus = 1'b1;
        bus_if.store_hi       = 1'b1;
        #1 check_val({tag, "_hi"}, data_bus, v[15:8]);
        do_cycle();
        bus_if.store_hi = 1'b0;
        #1 check_val({tag, "_lo"}, data_bus, v[7:0]);
        do_cycle();
    endtask

    initial begin
        for (int i = 0; i < N; i++) m_regs[i] = '0;
        idle();
        reset = 1'b1;
        @(negedge clock);
        do_cycle();
        do_cycle();
        reset = 1'b0;
        check_val("rst_bcd_out", bus_if.bcd_out, 20'h0);
        check_val("rst_valid", bus_if.bcd_valid, 0);
        check_val("rst_busy", bus_if.bcd_busy, 0);

        // ADD with carry out into the upper half
        write_reg(1, 8'hC8);
        write_reg(2, 8'h64);
        read_reg(1);
        grab_op(4'd0, 8'h64);
        check_val("add_carry", bus_if.flag_carry, 1);
        check_val("add_zero", bus_if.flag_zero, 0);
        check_val("add_busy", bus_if.bcd_busy, 1);
        idle_n(15);
        check_val("add_not_yet", bus_if.bcd_valid, 0);
        idle_n(1);
        check_val("add_bcd", bus_if.bcd_out, 20'h00300);
        check_val("add_valid", bus_if.bcd_valid, 1);
        check_latch("add_latch", 16'h012C);

        // Full-width multiply
        write_reg(0, 8'hFF);
        read_reg(0);
        grab_op(4'd8, 8'hFF);
        check_val("mul_carry", bus_if.flag_carry, 1);
        idle_n(16);
        check_val("mul_bcd", bus_if.bcd_out, 20'h65025);
        check_latch("mul_latch", 16'hFE01);

        // Zero result
        write_reg(0, 8'h05);
        read_reg(0);
        grab_op(4'd1, 8'h05);
        check_val("sub_zero", bus_if.flag_zero, 1);
        check_val("sub_carry", bus_if.flag_carry, 0);
        idle_n(16);
        check_val("sub_bcd", bus_if.bcd_out, 20'h00000);
        check_val("sub_valid", bus_if.bcd_valid, 1);

        // Restart mid-conversion
        grab_op(4'd9, 8'd250);
        idle_n(4);
        grab_op(4'd9, 8'd7);
        for (int i = 0; i < 15; i++) begin
            idle_n(1);
            check_val("restart_busy", bus_if.bcd_busy, 1);
            check_val("restart_no250", 32'(bus_if.bcd_out != 20'h00250), 1);
        end
        idle_n(1);
        check_val("restart_bcd", bus_if.bcd_out, 20'h00007);
        check_val("restart_valid", bus_if.bcd_valid, 1);

        // Reset in the middle of a conversion
        grab_op(4'd9, 8'h99);
        idle_n(8);
        idle();
        reset = 1'b1;
        bus_if.store_data_bus = 1'b1;
        do_cycle();
        check_val("midrst_bcd", bus_if.bcd_out, 0);
        check_val("midrst_busy", bus_if.bcd_busy, 0);
        check_val("midrst_valid", bus_if.bcd_valid, 0);
        check_val("midrst_zero", bus_if.flag_zero, 0);
        check_val("midrst_carry", bus_if.flag_carry, 0);
        #1 check_val("midrst_bus_z", data_bus, 8'hFF);
        do_cycle();
        reset = 1'b0;

        // Register move from the latch
        grab_op(4'd9, 8'h42);
        idle();
        bus_if.store_data_bus = 1'b1;
        bus_if.gp_reg_write   = 1'b1;
        bus_if.reg_sel        = 2'd3;
        do_cycle();
        read_reg(3);
        grab_op(4'd0, 8'h00);
        idle();
        bus_if.store_data_bus = 1'b1;
        #1 check_val("move_opnd", data_bus, 8'h42);
        bus_if.store_data_bus = 1'b0;
        #1 check_val("move_float", data_bus, 8'hFF);
        do_cycle();

        // Randomized traffic
        for (int n = 0; n < 800; n++) begin
            idle();
            reset                 = ($urandom_range(0, 59) == 0);
            bus_if.reg_sel        = 2'($urandom_range(0, 3));
            bus_if.gp_reg_write   = ($urandom_range(0, 2) == 0);
            bus_if.gp_reg_read    = ($urandom_range(0, 2) == 0);
            bus_if.ula_operation  = 4'($urandom_range(0, 15));
            bus_if.grab_ula       = ($urandom_range(0, 7) == 0);
            bus_if.store_data_bus = ($urandom_range(0, 3) == 0);
            bus_if.store_hi       = 1'($urandom_range(0, 1));
            tb_en  = !bus_if.store_data_bus && ($urandom_range(0, 7) != 0);
            case ($urandom_range(0, 3))
                0:       tb_val = 8'h00;
                1:       tb_val = 8'hFF;
                default: tb_val = 8'($urandom);
            endcase
            do_cycle();
        end
        reset = 1'b0;
        idle_n(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/param_datapath.md
PARAM_DATAPATH -- requirements
Module: param_datapath

Interface
REQ-001 Parameter WIDTH, default 8, data bus and register width in bits; SHALL be at least 4.
REQ-002 Parameter NREGS, default 4, number of general registers; SHALL be a power of 2 and at least 2.
REQ-003 Parameter DIGITS, default 5, BCD digits; SHALL satisfy 10^DIGITS > 2^(2*WIDTH).
REQ-004 Port clock, input, 1, sole clock, rising edge.
REQ-005 Port reset, input, 1, synchronous active-high reset, sampled on the clock rising edge.
REQ-006 Port reg_sel, input, log2(NREGS), register index for read and write.
REQ-007 Port gp_reg_write, input, 1, writes data_bus into the register selected by reg_sel.
REQ-008 Port gp_reg_read, input, 1, loads the register selected by reg_sel into the operand register.
REQ-009 Port ula_operation, input, 4, ALU opcode.
REQ-010 Port grab_ula, input, 1, captures the ALU result and flags, and starts BCD conversion.
REQ-011 Port store_data_bus, input, 1, drives the result latch onto data_bus.
REQ-012 Port store_hi, input, 1, selects which half of the result latch is driven: 1 = upper WIDTH bits, 0 = lower WIDTH bits.
REQ-013 Port data_bus, inout, WIDTH, shared tristate bus.
REQ-014 Port flag_zero and port flag_carry, output, 1 each, flags captured by grab_ula.
REQ-015 Port bcd_out, output, 4*DIGITS, BCD of the result latch; digit 0 is in bits [3:0].
REQ-016 Port bcd_busy and port bcd_valid, output, 1 each, conversion status.

Function
REQ-017 Register file: NREGS x WIDTH; on gp_reg_write, regs[reg_sel] <= data_bus at the clock edge.
REQ-018 Operand register: on gp_reg_read, opnd <= regs[reg_sel]; if gp_reg_write targets the same index in the same cycle, opnd SHALL take the old value.
REQ-019 ALU: combinational, with A = opnd and B = data_bus, producing a 2*WIDTH-bit result R and a carry C.
REQ-020 ALU opcodes:
- 0 ADD: R = A+B, zero-extended; C = carry out of bit WIDTH-1.
- 1 SUB: R = A-B, low WIDTH bits only, upper half 0; C = borrow.
- 2 AND, 3 OR, 4 XOR, 5 NOT A, 9 PASS B: results zero-extended; C = 0.
- 6 SHL: R = A<<1 zero-extended; C = A[WIDTH-1].
- 7 SHR: R = A>>1; C = A[0].
- 8 MUL: R = A*B unsigned, full 2*WIDTH bits; C = (upper half != 0).
- 10 to 15: R = 0, C = 0.
REQ-021 On grab_ula, the result latch <= R, flag_carry <= C, and flag_zero <= (R == 0).
REQ-022 data_bus SHALL be driven from the result latch only while store_data_bus = 1 (upper or lower half per store_hi), and SHALL be high-Z otherwise.
REQ-023 store_data_bus and gp_reg_write asserted together SHALL copy the driven latch half into regs[reg_sel] (register-move path).
REQ-024 BCD converter FSM: states IDLE and SHIFT; conversion is double-dabble, one shift per clock.
REQ-025 A grab_ula at edge k SHALL load the shifter from R, enter SHIFT, clear the counter, set bcd_busy = 1, and clear bcd_valid.
REQ-026 Each edge in SHIFT SHALL add 3 to every digit that is >= 5, then shift left by 1 and increment the counter.
REQ-027 On the (2*WIDTH)th shift, at edge k+2*WIDTH, the FSM SHALL load bcd_out, set bcd_valid = 1, set bcd_busy = 0, and return to IDLE.
REQ-028 bcd_out SHALL hold its previous value throughout a conversion.
REQ-029 A grab_ula during SHIFT SHALL abort the current conversion and restart per REQ-025 with the new R.
REQ-030 bcd_valid SHALL remain 1 until the next grab_ula or reset.
REQ-031 Simultaneous grab_ula and store_data_bus: the bus SHALL carry the pre-edge latch value, and the latch SHALL update at the edge.

Reset
REQ-032 On reset, all registers, opnd, the result latch, both flags, bcd_out, bcd_valid and bcd_busy SHALL be 0, and the FSM SHALL be IDLE.
REQ-033 data_bus SHALL be high-Z while reset is asserted.
REQ-034 Reset during SHIFT SHALL abandon the conversion; reset SHALL have priority over all other inputs in the same cycle.

Verification (WIDTH=8, NREGS=4, DIGITS=5)
REQ-035 Write 0xC8 to r1 and 0x64 to r2, read r1, bus = 0x64, op 0 ADD, grab -> latch 0x012C, carry = 1, zero = 0; 16 cycles later bcd_out = 0x00300, bcd_valid = 1.
REQ-036 opnd = 0xFF, bus = 0xFF, op 8 MUL, grab -> latch 0xFE01, carry = 1; bcd_out = 0x65025 after 16 cycles; store_data_bus with store_hi = 1 drives 0xFE, with store_hi = 0 drives 0x01.
REQ-037 opnd = 0x05, bus = 0x05, op 1 SUB, grab -> latch 0, zero = 1, carry = 0, bcd_out = 0x00000, bcd_valid = 1.
REQ-038 Grab 250, then grab 7 five cycles later -> bcd_busy stays 1, and bcd_out = 0x00007 exactly 16 cycles after the second grab, with 250 never appearing on bcd_out.
REQ-039 Assert reset at shift 8 of a conversion -> next cycle all outputs 0, bcd_busy = 0, data_bus high-Z.
REQ-040 Register move: latch 0x0042 with store_data_bus = 1 and gp_reg_write = 1 to r3, then gp_reg_read r3 -> opnd = 0x42; with store_data_bus = 0 the bus floats (monitor shows Z).
